seq_nor_accum: RTL and testbench

//   Parametrised, clocked successor to the 2-input combinational NOR cell.

---
 rtl/seq_nor_accum.sv | 114 +++++++++++
 tb/tb_seq_nor_accum.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_nor_accum.sv
// Multi-beat bitwise reducer (NOR/OR/NAND/AND) with valid/ready in and out.
// Optional SEQ_NOR_STATUS_EN adds registered out_zero/out_ones result flags.
module seq_nor_accum #(
  parameter int WIDTH   = 8,
  parameter int NUM_OPS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef SEQ_NOR_STATUS_EN
  output logic             out_zero,
  output logic             out_ones,
`endif
  output logic             busy
);

  localparam int CW = (NUM_OPS > 2) ? $clog2(NUM_OPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_OPS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [1:0]       mode_q, mode_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] out_data_d;
  logic [WIDTH-1:0] merged;
  logic             accept;

  assign accept = in_valid & in_ready;
  // mode_q[1] selects the AND family; mode_q[0]=0 means the inverted form.
  assign merged = mode_q[1] ? (acc_q & in_data) : (acc_q | in_data);

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mode_d     = mode_q;
    count_d    = count_q;
    out_data_d = out_data;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = in_data;
          mode_d  = mode;
          count_d = CW'(1);
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = merged;
          if (count_q == LAST) begin
            // count holds here; it only returns to zero on leaving DONE.
            state_d    = DONE;
            out_data_d = mode_q[0] ? merged : ~merged;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mode_q    <= '0;
      count_q   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mode_q    <= mode_d;
      count_q   <= count_d;
      in_ready  <= (state_d != DONE);
      out_valid <= (state_d == DONE);
      out_data  <= out_data_d;
      busy      <= (state_d != IDLE);
    end
  end

`ifdef SEQ_NOR_STATUS_EN
  // Flags follow out_valid: loaded with the result, cleared on handoff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_zero <= 1'b0;
      out_ones <= 1'b0;
    end else begin
      out_zero <= (state_d == DONE) && (out_data_d == '0);
      out_ones <= (state_d == DONE) && (out_data_d == {WIDTH{1'b1}});
    end
  end
`endif

endmodule

// File: tb/tb_seq_nor_accum.sv
// Scoreboard bench for seq_nor_accum (WIDTH=8, NUM_OPS=4); per-scenario tasks.
// Build with +define+SEQ_NOR_STATUS_EN to also exercise the status flags.
module tb_seq_nor_accum;
  localparam int WIDTH   = 8;
  localparam int NUM_OPS = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;
`ifdef SEQ_NOR_STATUS_EN
  logic             out_zero;
  logic             out_ones;
`endif

  int compared   = 0;
  int mismatched = 0;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  seq_nor_accum #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef SEQ_NOR_STATUS_EN
    .out_zero  (out_zero),
    .out_ones  (out_ones),
`endif
    .busy      (busy)
  );

  function automatic logic [WIDTH-1:0] model(input logic [1:0] m,
      input logic [WIDTH-1:0] b0, b1, b2, b3);
    case (m)
      2'b00:   return ~(b0 | b1 | b2 | b3);
      2'b01:   return  (b0 | b1 | b2 | b3);
      2'b10:   return ~(b0 & b1 & b2 & b3);
      default: return  (b0 & b1 & b2 & b3);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand and hold it until the block accepts it.
  task automatic send_beat(input logic [WIDTH-1:0] d, input logic [1:0] m);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    mode     = m;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL beat_accept_timeout: in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Full transaction: mode m on the first beat, m_late afterwards (must be ignored).
  task automatic run_txn(input logic [1:0] m, input logic [1:0] m_late,
      input logic [WIDTH-1:0] b0, b1, b2, b3, input int gap);
    logic [WIDTH-1:0] beats [4];
    beats = '{b0, b1, b2, b3};
    exp_q.push_back(model(m, b0, b1, b2, b3));
    for (int i = 0; i < NUM_OPS; i++) begin
      send_beat(beats[i], (i == 0) ? m : m_late);
      if (i < NUM_OPS - 1 && gap > 0) begin
        repeat (gap) tick();
        compared++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
          mismatched++;
          $display("FAIL gap_hold: busy=%b out_valid=%b required 1/0", busy, out_valid);
        end
      end
    end
    compared++;
    if (out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL last_beat_latency: out_valid=%b required 1", out_valid);
    end
  endtask

  // Wait for a result, compare against the scoreboard, then hand it off.
  task automatic collect(input string name);
    logic [WIDTH-1:0] exp;
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    compared++;
    if (out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_timeout: out_valid=%b required 1", name, out_valid);
      return;
    end
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL %s_unexpected: out_data=%h required no result", name, out_data);
    end else begin
      exp = exp_q.pop_front();
      if (out_data !== exp) begin
        mismatched++;
        $display("FAIL %s_data: out_data=%h required %h", name, out_data, exp);
      end
`ifdef SEQ_NOR_STATUS_EN
      compared++;
      if (out_zero !== (exp == '0) || out_ones !== (exp == '1)) begin
        mismatched++;
        $display("FAIL %s_status: zero/ones=%b%b required %b%b", name,
                 out_zero, out_ones, (exp == '0), (exp == '1));
      end
`endif
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    compared++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_handoff: valid/busy/ready=%b%b%b required 001",
               name, out_valid, busy, in_ready);
    end
  endtask

  task automatic check_reset_values(input string name);
    compared++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL %s: ready/valid/busy=%b%b%b data=%h required 000 data=00",
               name, in_ready, out_valid, busy, out_data);
    end
`ifdef SEQ_NOR_STATUS_EN
    compared++;
    if (out_zero !== 1'b0 || out_ones !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_status: zero/ones=%b%b required 00", name, out_zero, out_ones);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    check_reset_values("reset_values");
    rst = 1'b0;
    #1;
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release_ready_early: in_ready=%b required 0", in_ready);
    end
    tick();
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_nor();
    run_txn(2'b00, 2'b00, 8'h01, 8'h02, 8'h04, 8'h00, 0);
    collect("nor_f8");
  endtask

  task automatic test_and_nand();
    run_txn(2'b11, 2'b11, 8'hFF, 8'hF0, 8'h3C, 8'hFC, 0);
    collect("and_30");
    run_txn(2'b10, 2'b10, 8'hFF, 8'hF0, 8'h3C, 8'hFC, 0);
    collect("nand_cf");
  endtask

  task automatic test_stall();
    logic [WIDTH-1:0] held;
    run_txn(2'b00, 2'b00, 8'h11, 8'h22, 8'h00, 8'h08, 0);
    held = out_data;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (5) begin
      tick();
      compared++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== held) begin
        mismatched++;
        $display("FAIL stall_stable: valid/ready=%b%b data=%h required 10 data=%h",
                 out_valid, in_ready, out_data, held);
      end
    end
    in_valid = 1'b0;
    collect("stall_result");
    run_txn(2'b01, 2'b01, 8'h01, 8'h02, 8'h03, 8'h04, 0);
    collect("after_stall");
  endtask

  task automatic test_gaps_mode();
    run_txn(2'b01, 2'b11, 8'h10, 8'h20, 8'h40, 8'h80, 2);
    collect("gaps_or_f0");
  endtask

  task automatic test_abort();
    send_beat(8'hFF, 2'b00);
    send_beat(8'hFF, 2'b00);
    rst = 1'b1;
    #1;
    check_reset_values("abort_reset");
    tick();
    rst = 1'b0;
    tick();
    repeat (3) tick();
    compared++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_no_partial: valid/busy=%b%b required 00", out_valid, busy);
    end
    run_txn(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    collect("abort_fresh_ff");
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    mode      = 2'b00;
    out_ready = 1'b0;
    test_reset();
    test_nor();
    test_and_nand();
    test_stall();
    test_gaps_mode();
    test_abort();
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
